efi_cfg_bank: RTL

// Parametrised configuration/status bank for the EFI core, sitting between the SPI slave (already in clk domain) and the sync/ign/inj drivers.

---
 rtl/efi_cfg_bank_if.sv | 26 ++
 rtl/efi_cfg_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/efi_cfg_bank_if.sv
// Register-access bus between the SPI slave and the EFI configuration bank.
// The SPI side (master) issues single-cycle writes and reads; the bank (slave)
// returns registered read data one cycle after the read address.
interface efi_cfg_bank_if;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/efi_cfg_bank.sv
// EFI configuration/status bank.
// SPI writes land in a shadow set; the shadow is copied to the active set in
// one edge (every cycle while unsynced, otherwise at cycle_start when dirty),
// so the sync/ign/inj drivers only ever see a complete configuration.
// A sequential restoring divider turns the summed tooth period into rpm, and a
// rev limiter with release hysteresis masks the channel enables.
module efi_cfg_bank #(
  parameter int          NUM_IGN      = 4,
  parameter int          NUM_INJ      = 2,
  parameter int unsigned RPM_DIVIDEND = 32'd64_000_000,
  parameter int unsigned REV_HYST     = 32'd200
) (
  input  logic                    clk,
  input  logic                    reset_n,
  efi_cfg_bank_if.slave           bus,
  input  logic                    synced,
  input  logic                    trigger,
  input  logic                    cycle_start,
  input  logic [31:0]             period_sum,
  output logic                    distributor_mode,
  output logic [NUM_IGN-1:0]      en_ign,
  output logic [NUM_INJ-1:0]      en_inj,
  output logic [15:0]             tooth_cnt,
  output logic [15:0]             teeth_missing,
  output logic [15:0]             ign_timing,
  output logic [15:0]             dwell,
  output logic [15:0]             quanta_per_rev,
  output logic [16*NUM_IGN-1:0]   ign_phase_flat,
  output logic [16*NUM_INJ-1:0]   inj_pw_flat,
  output logic [15:0]             rpm,
  output logic                    limiter_active
);

  // Register map layout
  localparam int         IDX_CTRL    = 0;
  localparam int         IDX_TOOTH   = 1;
  localparam int         IDX_MISSING = 2;
  localparam int         IDX_TIMING  = 3;
  localparam int         IDX_DWELL   = 4;
  localparam int         IDX_REVLIM  = 5;
  localparam int         IGN_BASE    = 6;
  localparam int         INJ_BASE    = 6 + NUM_IGN;
  localparam int         NUM_CFG     = 6 + NUM_IGN + NUM_INJ;
  localparam int         IDX_W       = $clog2(NUM_CFG);
  localparam logic [6:0] NUM_CFG_A   = 7'(NUM_CFG);
  localparam logic [6:0] ADDR_SYNCED = 7'h40;
  localparam logic [6:0] ADDR_RPM    = 7'h41;
  localparam logic [6:0] ADDR_STATUS = 7'h42;

  localparam logic [15:0] TOOTH_DEF  = 16'd60;
  localparam logic [15:0] REV_HYST_W = 16'(REV_HYST);
  localparam logic [31:0] DIVIDEND_W = 32'(RPM_DIVIDEND);

  // Power-on value of each configuration register (shadow and active alike).
  function automatic logic [15:0] cfg_default(input int idx);
    logic [15:0] val;
    val = 16'h0000;
    if (idx == IDX_CTRL) begin
      for (int b = 0; b < NUM_IGN; b++) val[b] = 1'b1;
      for (int b = 0; b < NUM_INJ; b++) val[8+b] = 1'b1;
    end else if (idx == IDX_TOOTH) begin
      val = TOOTH_DEF;
    end else if (idx == IDX_MISSING) begin
      val = 16'd2;
    end else if (idx == IDX_TIMING) begin
      val = 16'd342;
    end else if (idx == IDX_DWELL) begin
      val = 16'd342;
    end else if (idx >= IGN_BASE && idx < INJ_BASE) begin
      val = 16'((idx - IGN_BASE) * (15360 / NUM_IGN));
    end else if (idx == INJ_BASE) begin
      val = 16'd2000;
    end else begin
      val = 16'h0000;
    end
    return val;
  endfunction

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  logic [15:0] shadow_r [NUM_CFG];
  logic [15:0] active_r [NUM_CFG];
  logic        dirty_r;
  logic        cfg_wr_s;
  logic        commit_s;
  logic [15:0] rd_next_s;
  logic [15:0] qpr_r;

  div_state_e  state_r;
  div_state_e  state_n_s;
  logic [31:0] div_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [4:0]  cnt_r;
  logic [32:0] rem_shift_s;
  logic [32:0] rem_diff_s;
  logic [31:0] rem_step_s;
  logic [31:0] quo_step_s;
  logic [15:0] rpm_sat_s;
  logic [15:0] rpm_r;
  logic        limiter_r;
  logic [15:0] rev_limit_s;
  logic [15:0] release_thr_s;
  logic        div_busy_s;
  logic        run_ok_s;

  assign cfg_wr_s   = bus.wr_en && (bus.wr_addr < NUM_CFG_A);
  assign commit_s   = !synced || (cycle_start && dirty_r);
  assign div_busy_s = (state_r != DIV_IDLE);
  assign run_ok_s   = synced && !limiter_r;

  // Shadow/active configuration sets and the pending-commit flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        shadow_r[i] <= cfg_default(i);
        active_r[i] <= cfg_default(i);
      end
      dirty_r <= 1'b0;
    end else begin
      // The commit copies the pre-write shadow; a coincident write stays pending.
      if (commit_s) begin
        for (int i = 0; i < NUM_CFG; i++) active_r[i] <= shadow_r[i];
      end
      if (cfg_wr_s) begin
        shadow_r[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
      end
      if (cfg_wr_s) begin
        dirty_r <= 1'b1;
      end else if (commit_s) begin
        dirty_r <= 1'b0;
      end else begin
        dirty_r <= dirty_r;
      end
    end
  end

  // Read mux: shadow for config addresses, live status, zero elsewhere.
  always_comb begin
    rd_next_s = 16'h0000;
    if (bus.rd_addr < NUM_CFG_A) begin
      rd_next_s = shadow_r[bus.rd_addr[IDX_W-1:0]];
    end else begin
      case (bus.rd_addr)
        ADDR_SYNCED: rd_next_s = {15'b0, synced};
        ADDR_RPM:    rd_next_s = rpm;
        ADDR_STATUS: rd_next_s = {13'b0, div_busy_s, dirty_r, limiter_r};
        default:     rd_next_s = 16'h0000;
      endcase
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rd_data <= 16'h0000;
    end else begin
      bus.rd_data <= rd_next_s;
    end
  end

  // Quanta per revolution follows the active tooth count (tooth_cnt * 256).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      qpr_r <= {TOOTH_DEF[7:0], 8'h00};
    end else begin
      qpr_r <= {active_r[IDX_TOOTH][7:0], 8'h00};
    end
  end

  // Divider next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (trigger) state_n_s = DIV_RUN;
        else         state_n_s = DIV_IDLE;
      end
      DIV_RUN: begin
        if (cnt_r == 5'd31) state_n_s = DIV_DONE;
        else                state_n_s = DIV_RUN;
      end
      DIV_DONE: state_n_s = DIV_IDLE;
      default:  state_n_s = DIV_IDLE;
    endcase
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // One restoring-division step; a zero divisor yields an all-ones quotient.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[31]};
    rem_diff_s  = rem_shift_s - {1'b0, div_r};
    if (rem_shift_s >= {1'b0, div_r}) begin
      rem_step_s = rem_diff_s[31:0];
      quo_step_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_step_s = rem_shift_s[31:0];
      quo_step_s = {quo_r[30:0], 1'b0};
    end
    if (quo_r[31:16] != 16'h0000) rpm_sat_s = 16'hFFFF;
    else                          rpm_sat_s = quo_r[15:0];
  end

  // Divider datapath and rpm result register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_r <= 32'h0000_0000;
      quo_r <= 32'h0000_0000;
      rem_r <= 32'h0000_0000;
      cnt_r <= 5'd0;
      rpm_r <= 16'h0000;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (trigger) begin
            div_r <= period_sum;
            quo_r <= DIVIDEND_W;
            rem_r <= 32'h0000_0000;
            cnt_r <= 5'd0;
          end
        end
        DIV_RUN: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r + 5'd1;
        end
        DIV_DONE: rpm_r <= rpm_sat_s;
        default:  cnt_r <= 5'd0;
      endcase
    end
  end

  // Limiter release threshold, floored at zero.
  always_comb begin
    rev_limit_s = active_r[IDX_REVLIM];
    if (rev_limit_s > REV_HYST_W) release_thr_s = rev_limit_s - REV_HYST_W;
    else                          release_thr_s = 16'h0000;
  end

  // Rev limiter, re-evaluated whenever a new rpm value is loaded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      limiter_r <= 1'b0;
    end else if (!synced) begin
      limiter_r <= 1'b0;
    end else if (state_r == DIV_DONE) begin
      if (rev_limit_s == 16'h0000)      limiter_r <= 1'b0;
      else if (rpm_sat_s >= rev_limit_s) limiter_r <= 1'b1;
      else if (rpm_sat_s < release_thr_s) limiter_r <= 1'b0;
      else                               limiter_r <= limiter_r;
    end else begin
      limiter_r <= limiter_r;
    end
  end

  assign distributor_mode = active_r[IDX_CTRL][15];
  assign en_ign           = active_r[IDX_CTRL][NUM_IGN-1:0] & {NUM_IGN{run_ok_s}};
  assign en_inj           = active_r[IDX_CTRL][8+NUM_INJ-1:8] & {NUM_INJ{run_ok_s}};
  assign tooth_cnt        = active_r[IDX_TOOTH];
  assign teeth_missing    = active_r[IDX_MISSING];
  assign ign_timing       = active_r[IDX_TIMING];
  assign dwell            = active_r[IDX_DWELL];
  assign quanta_per_rev   = qpr_r;
  assign rpm              = synced ? rpm_r : 16'h0000;
  assign limiter_active   = limiter_r;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IGN; gi++) begin : g_ign
      assign ign_phase_flat[16*gi +: 16] = active_r[IGN_BASE+gi];
    end
    for (gi = 0; gi < NUM_INJ; gi++) begin : g_inj
      assign inj_pw_flat[16*gi +: 16] = active_r[INJ_BASE+gi];
    end
  endgenerate

endmodule
